// File: rtl/fir_lms_core.sv
// -----------------------------------------------------------------------------
// fir_lms_core
//
// Adaptive FIR datapath. A single time-multiplexed signed MAC evaluates a
// TAPS-tap FIR for every accepted sample. An optional LMS pass then adapts
// the coefficients using the freshly computed error.
//
// Sequence per sample: IDLE -> FILTER (TAPS cycles) -> ERROR (1 cycle)
//   -> UPDATE (TAPS cycles, only if adapt_en was set at accept) -> DONE.
//
// Optional build macro: FIR_COEF_READBACK_EN adds a registered coefficient
// readback port (coef_rd_addr / coef_rd_data).
//
// Ports:
//   S_AXI_ACLK      clock
//   S_AXI_ARESETN   synchronous active-low reset
//   sample_valid    x_in/d_in pair present
//   sample_ready    core idle and will accept
//   x_in, d_in      input and desired sample, signed Q1.(DATA_W-1)
//   adapt_en        run LMS update for this sample (latched at accept)
//   mu_shift        LMS step size 2^-mu_shift (latched at accept)
//   coef_wr_en/addr/data  coefficient write, honoured only in IDLE
//   coef_wr_drop    one-cycle pulse when a write was ignored
//   soft_clear      zero the delay line (IDLE only)
//   result_valid / result_ready  result handshake
//   y_out, e_out    saturated filter output and error d - y
//   busy            core not idle
//   coef_rd_addr/coef_rd_data    (FIR_COEF_READBACK_EN only) registered readback
// -----------------------------------------------------------------------------
module fir_lms_core #(
   parameter int TAPS   = 8,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 40,
   localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic              S_AXI_ACLK,
   input  logic              S_AXI_ARESETN,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] d_in,
   input  logic              adapt_en,
   input  logic [3:0]        mu_shift,
   input  logic              coef_wr_en,
   input  logic [AW-1:0]     coef_wr_addr,
   input  logic [COEF_W-1:0] coef_wr_data,
   output logic              coef_wr_drop,
   input  logic              soft_clear,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [DATA_W-1:0] y_out,
   output logic [DATA_W-1:0] e_out,
   output logic              busy
`ifdef FIR_COEF_READBACK_EN
   ,
   input  logic [AW-1:0]     coef_rd_addr,
   output logic [COEF_W-1:0] coef_rd_data
`endif
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ERR_W  = DATA_W + 1;
   localparam int UPD_W  = ((2 * DATA_W > COEF_W) ? 2 * DATA_W : COEF_W) + 1;
   localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

   localparam logic signed [ACC_W-1:0] ACC_MAX =
      {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
   localparam logic signed [ERR_W-1:0] ERR_MAX = {2'b00, {(DATA_W - 1){1'b1}}};
   localparam logic signed [ERR_W-1:0] ERR_MIN = ~ERR_MAX;
   localparam logic signed [UPD_W-1:0] UPD_MAX =
      {{(UPD_W - COEF_W + 1){1'b0}}, {(COEF_W - 1){1'b1}}};
   localparam logic signed [UPD_W-1:0] UPD_MIN = ~UPD_MAX;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILTER,
      S_ERROR,
      S_UPDATE,
      S_DONE
   } state_t;

   function automatic logic signed [DATA_W-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
      if (v > ACC_MAX)      return ACC_MAX[DATA_W-1:0];
      else if (v < ACC_MIN) return ACC_MIN[DATA_W-1:0];
      else                  return v[DATA_W-1:0];
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_err(input logic signed [ERR_W-1:0] v);
      if (v > ERR_MAX)      return ERR_MAX[DATA_W-1:0];
      else if (v < ERR_MIN) return ERR_MIN[DATA_W-1:0];
      else                  return v[DATA_W-1:0];
   endfunction

   function automatic logic signed [COEF_W-1:0] sat_upd(input logic signed [UPD_W-1:0] v);
      if (v > UPD_MAX)      return UPD_MAX[COEF_W-1:0];
      else if (v < UPD_MIN) return UPD_MIN[COEF_W-1:0];
      else                  return v[COEF_W-1:0];
   endfunction

   state_t                    state_q, state_d;
   logic [AW-1:0]             k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [DATA_W-1:0]  x_q [TAPS];
   logic signed [DATA_W-1:0]  x_d [TAPS];
   logic signed [COEF_W-1:0]  h_q [TAPS];
   logic signed [COEF_W-1:0]  h_d [TAPS];
   logic signed [DATA_W-1:0]  d_q, d_d;
   logic                      adapt_q, adapt_d;
   logic [3:0]                mu_q, mu_d;
   logic signed [DATA_W-1:0]  y_q, y_d;
   logic signed [DATA_W-1:0]  e_q, e_d;
   logic                      drop_q, drop_d;

   // FILTER stage: one full-width product per cycle, sign-extended into acc
   logic signed [PROD_W-1:0]  mac_prod;
   logic signed [ACC_W-1:0]   mac_ext;
   assign mac_prod = h_q[k_q] * x_q[k_q];
   assign mac_ext  = ACC_W'(mac_prod);

   // ERROR stage: rescale Q(2.x) accumulator back to sample format, then d - y
   logic signed [ACC_W-1:0]   acc_sh;
   logic signed [DATA_W-1:0]  y_new;
   logic signed [ERR_W-1:0]   err_w;
   logic signed [DATA_W-1:0]  e_new;
   assign acc_sh = acc_q >>> (COEF_W - 1);
   assign y_new  = sat_acc(acc_sh);
   assign err_w  = ERR_W'(d_q) - ERR_W'(y_new);
   assign e_new  = sat_err(err_w);

   // UPDATE stage: h[k] += (e * x[k]) >>> (DATA_W-1+mu), floor rounding
   logic signed [2*DATA_W-1:0] upd_prod;
   logic signed [2*DATA_W-1:0] upd_shd;
   logic [7:0]                 upd_sh;
   logic signed [UPD_W-1:0]    upd_sum;
   assign upd_prod = e_q * x_q[k_q];
   assign upd_sh   = 8'(DATA_W - 1) + 8'(mu_q);
   assign upd_shd  = upd_prod >>> upd_sh;
   assign upd_sum  = UPD_W'(h_q[k_q]) + UPD_W'(upd_shd);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      x_d     = x_q;
      h_d     = h_q;
      d_d     = d_q;
      adapt_d = adapt_q;
      mu_d    = mu_q;
      y_d     = y_q;
      e_d     = e_q;
      drop_d  = coef_wr_en && (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            // A same-cycle write lands before the FILTER pass reads h.
            if (coef_wr_en) h_d[coef_wr_addr] = coef_wr_data;
            if (soft_clear) begin
               for (int i = 0; i < TAPS; i++) x_d[i] = '0;
            end
            if (sample_valid) begin
               // Clear beats the shift for the older taps; x_in still enters tap 0.
               x_d[0] = x_in;
               for (int i = 1; i < TAPS; i++) x_d[i] = soft_clear ? '0 : x_q[i-1];
               d_d     = d_in;
               adapt_d = adapt_en;
               mu_d    = mu_shift;
               acc_d   = '0;
               k_d     = '0;
               state_d = S_FILTER;
            end
         end
         S_FILTER: begin
            acc_d = acc_q + mac_ext;
            k_d   = k_q + AW'(1);
            if (k_q == K_LAST) state_d = S_ERROR;
         end
         S_ERROR: begin
            y_d     = y_new;
            e_d     = e_new;
            k_d     = '0;
            state_d = adapt_q ? S_UPDATE : S_DONE;
         end
         S_UPDATE: begin
            h_d[k_q] = sat_upd(upd_sum);
            k_d      = k_q + AW'(1);
            if (k_q == K_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            if (result_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            h_q[i] <= '0;
         end
         d_q     <= '0;
         adapt_q <= 1'b0;
         mu_q    <= '0;
         y_q     <= '0;
         e_q     <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         h_q     <= h_d;
         d_q     <= d_d;
         adapt_q <= adapt_d;
         mu_q    <= mu_d;
         y_q     <= y_d;
         e_q     <= e_d;
         drop_q  <= drop_d;
      end
   end

`ifdef FIR_COEF_READBACK_EN
   // Reads the live register, so mid-UPDATE it reflects taps already adapted.
   logic [COEF_W-1:0] rd_q, rd_d;
   assign rd_d = h_q[coef_rd_addr];
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) rd_q <= '0;
      else                rd_q <= rd_d;
   end
   assign coef_rd_data = rd_q;
`endif

   assign sample_ready = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_DONE);
   assign y_out        = y_q;
   assign e_out        = e_q;
   assign coef_wr_drop = drop_q;

endmodule

// File: tb/tb_fir_lms_core.sv
// -----------------------------------------------------------------------------
// tb_fir_lms_core
//
// Directed testbench for fir_lms_core with TAPS=8, DATA_W=COEF_W=16.
// Inputs change 1 time unit after a rising edge; outputs are read at that
// same point, i.e. after the registers have settled.
// -----------------------------------------------------------------------------
module tb_fir_lms_core;

   localparam int TAPS = 8;
   localparam int DW   = 16;
   localparam int CW   = 16;
   localparam int AW   = 3;

   logic          clk;
   logic          rst_n;
   logic          sample_valid;
   logic          sample_ready;
   logic [DW-1:0] x_in;
   logic [DW-1:0] d_in;
   logic          adapt_en;
   logic [3:0]    mu_shift;
   logic          coef_wr_en;
   logic [AW-1:0] coef_wr_addr;
   logic [CW-1:0] coef_wr_data;
   logic          coef_wr_drop;
   logic          soft_clear;
   logic          result_valid;
   logic          result_ready;
   logic [DW-1:0] y_out;
   logic [DW-1:0] e_out;
   logic          busy;
`ifdef FIR_COEF_READBACK_EN
   logic [AW-1:0] coef_rd_addr;
   logic [CW-1:0] coef_rd_data;
`endif

   int n_cmp;
   int n_bad;

   fir_lms_core #(
      .TAPS   (TAPS),
      .DATA_W (DW),
      .COEF_W (CW),
      .ACC_W  (40)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .x_in          (x_in),
      .d_in          (d_in),
      .adapt_en      (adapt_en),
      .mu_shift      (mu_shift),
      .coef_wr_en    (coef_wr_en),
      .coef_wr_addr  (coef_wr_addr),
      .coef_wr_data  (coef_wr_data),
      .coef_wr_drop  (coef_wr_drop),
      .soft_clear    (soft_clear),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .y_out         (y_out),
      .e_out         (e_out),
      .busy          (busy)
`ifdef FIR_COEF_READBACK_EN
      ,
      .coef_rd_addr  (coef_rd_addr),
      .coef_rd_data  (coef_rd_data)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_coef(input logic [AW-1:0] a, input logic [CW-1:0] v);
      coef_wr_en   = 1'b1;
      coef_wr_addr = a;
      coef_wr_data = v;
      tick();
      coef_wr_en   = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] d,
                       input logic ad, input logic [3:0] mu, input logic clr);
      sample_valid = 1'b1;
      x_in         = x;
      d_in         = d;
      adapt_en     = ad;
      mu_shift     = mu;
      soft_clear   = clr;
      tick();
      sample_valid = 1'b0;
      soft_clear   = 1'b0;
   endtask

   // Returns the cycle index (accept cycle = 0) at which result_valid rose.
   task automatic wait_result(output int lat);
      lat = 1;
      while (!result_valid && lat < 100) begin
         tick();
         lat++;
      end
      if (!result_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL result_timeout: result_valid=%0b after %0d cycles, required 1", result_valid, lat);
      end
   endtask

   task automatic consume();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", sample_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %0b want 0", result_valid); end
      n_cmp++; if (y_out !== 16'h0000) begin n_bad++; $display("FAIL reset_y: got %h want 0000", y_out); end
      n_cmp++; if (e_out !== 16'h0000) begin n_bad++; $display("FAIL reset_e: got %h want 0000", e_out); end
      n_cmp++; if (coef_wr_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %0b want 0", coef_wr_drop); end
      rst_n = 1'b1;
      tick();
   endtask

   // Coefficient write and sample accept in the same IDLE cycle.
   task automatic test_single_tap();
      int lat;
      coef_wr_en   = 1'b1;
      coef_wr_addr = 3'd0;
      coef_wr_data = 16'h4000;
      send(16'h2000, 16'h0000, 1'b0, 4'd0, 1'b0);
      coef_wr_en   = 1'b0;
      n_cmp++; if (coef_wr_drop !== 1'b0) begin n_bad++; $display("FAIL idle_write_drop: got %0b want 0", coef_wr_drop); end
      wait_result(lat);
      n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL single_latency: got %0d want 10", lat); end
      n_cmp++; if (y_out !== 16'h1000) begin n_bad++; $display("FAIL single_y: got %h want 1000", y_out); end
      n_cmp++; if (e_out !== 16'hF000) begin n_bad++; $display("FAIL single_e: got %h want f000", e_out); end
      consume();
   endtask

   task automatic test_impulse();
      int lat;
      logic [DW-1:0] exp_y [8];
      exp_y = '{16'h00FF, 16'h01FF, 16'h02FF, 16'h03FF, 16'h04FF, 16'h05FF, 16'h06FF, 16'h07FF};
      for (int k = 0; k < TAPS; k++) wr_coef(3'(k), 16'(16'h0100 * (k + 1)));
      soft_clear = 1'b1;
      tick();
      soft_clear = 1'b0;
      for (int n = 0; n < TAPS; n++) begin
         send((n == 0) ? 16'h7FFF : 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0);
         wait_result(lat);
         n_cmp++; if (y_out !== exp_y[n]) begin n_bad++; $display("FAIL impulse_y[%0d]: got %h want %h", n, y_out, exp_y[n]); end
         consume();
      end
   endtask

   task automatic test_saturation();
      int lat;
      for (int k = 0; k < TAPS; k++) wr_coef(3'(k), 16'h7FFF);
      soft_clear = 1'b1;
      tick();
      soft_clear = 1'b0;
      for (int n = 0; n < TAPS; n++) begin
         send(16'h7FFF, 16'h8000, 1'b0, 4'd0, 1'b0);
         wait_result(lat);
         if (n < TAPS - 1) consume();
      end
      n_cmp++; if (y_out !== 16'h7FFF) begin n_bad++; $display("FAIL sat_y: got %h want 7fff", y_out); end
      n_cmp++; if (e_out !== 16'h8000) begin n_bad++; $display("FAIL sat_e: got %h want 8000", e_out); end
      // Consumer stalls for 5 cycles: result must not move.
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL hold_rvalid[%0d]: got %0b want 1", i, result_valid); end
         n_cmp++; if (y_out !== 16'h7FFF) begin n_bad++; $display("FAIL hold_y[%0d]: got %h want 7fff", i, y_out); end
         n_cmp++; if (e_out !== 16'h8000) begin n_bad++; $display("FAIL hold_e[%0d]: got %h want 8000", i, e_out); end
         tick();
      end
      consume();
      n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %0b want 0", result_valid); end
   endtask

   // soft_clear together with accept; LMS adapts h[0] to 0x2000 only.
   task automatic test_lms_update();
      int lat;
      logic [DW-1:0] exp_y [8];
      exp_y = '{16'h1FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      for (int k = 0; k < TAPS; k++) wr_coef(3'(k), 16'h0000);
      send(16'h4000, 16'h4000, 1'b1, 4'd0, 1'b1);
      wait_result(lat);
      n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL lms_latency: got %0d want 18", lat); end
      n_cmp++; if (y_out !== 16'h0000) begin n_bad++; $display("FAIL lms_y: got %h want 0000", y_out); end
      n_cmp++; if (e_out !== 16'h4000) begin n_bad++; $display("FAIL lms_e: got %h want 4000", e_out); end
      consume();
`ifdef FIR_COEF_READBACK_EN
      for (int k = 0; k < TAPS; k++) begin
         coef_rd_addr = 3'(k);
         tick();
         n_cmp++;
         if (coef_rd_data !== ((k == 0) ? 16'h2000 : 16'h0000)) begin
            n_bad++; $display("FAIL lms_readback[%0d]: got %h want %h", k, coef_rd_data, (k == 0) ? 16'h2000 : 16'h0000);
         end
      end
`endif
      // Probe adapted coefficients with an impulse: y[n] = h[n]*0x7FFF >>> 15.
      for (int n = 0; n < TAPS; n++) begin
         send((n == 0) ? 16'h7FFF : 16'h0000, 16'h0000, 1'b0, 4'd0, (n == 0) ? 1'b1 : 1'b0);
         wait_result(lat);
         n_cmp++; if (y_out !== exp_y[n]) begin n_bad++; $display("FAIL lms_probe_y[%0d]: got %h want %h", n, y_out, exp_y[n]); end
         consume();
      end
   endtask

   // Busy-state rules: no accept during FILTER, writes dropped during UPDATE.
   task automatic test_busy_rules();
      int lat;
      for (int k = 0; k < TAPS; k++) wr_coef(3'(k), 16'h0000);
      send(16'h3000, 16'h0000, 1'b1, 4'd0, 1'b1);       // now cycle 1
      tick();                                           // cycle 2, FILTER
      sample_valid = 1'b1;
      x_in         = 16'h7FFF;
      n_cmp++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL filter_ready: got %0b want 0", sample_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL filter_busy: got %0b want 1", busy); end
      tick();                                           // cycle 3
      sample_valid = 1'b0;
      repeat (8) tick();                                // cycle 11, UPDATE
      coef_wr_en   = 1'b1;
      coef_wr_addr = 3'd3;
      coef_wr_data = 16'h1234;
      tick();                                           // cycle 12
      coef_wr_en   = 1'b0;
      n_cmp++; if (coef_wr_drop !== 1'b1) begin n_bad++; $display("FAIL drop_pulse: got %0b want 1", coef_wr_drop); end
      tick();                                           // cycle 13
      n_cmp++; if (coef_wr_drop !== 1'b0) begin n_bad++; $display("FAIL drop_end: got %0b want 0", coef_wr_drop); end
      wait_result(lat);
      lat = lat + 12;
      n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL busy_latency: got %0d want 18", lat); end
      n_cmp++; if (y_out !== 16'h0000) begin n_bad++; $display("FAIL busy_y: got %h want 0000", y_out); end
      consume();
      n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL busy_idle_after: got %0b want 1", sample_ready); end
      // h[3] must still be zero: 4th output of an impulse reads h[3].
      for (int n = 0; n < 4; n++) begin
         send((n == 0) ? 16'h7FFF : 16'h0000, 16'h0000, 1'b0, 4'd0, (n == 0) ? 1'b1 : 1'b0);
         wait_result(lat);
         if (n == 3) begin
            n_cmp++; if (y_out !== 16'h0000) begin n_bad++; $display("FAIL dropped_write_h3: got %h want 0000", y_out); end
         end
         consume();
      end
   endtask

   // Handshakes held high: one result every TAPS+3 = 11 cycles.
   task automatic test_back_to_back();
      int first_c, second_c, n_valid;
      first_c  = -1;
      second_c = -1;
      n_valid  = 0;
      sample_valid = 1'b1;
      result_ready = 1'b1;
      x_in         = 16'h0100;
      d_in         = 16'h0000;
      adapt_en     = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         tick();
         if (result_valid) begin
            n_valid++;
            if (first_c < 0) first_c = c;
            else if (second_c < 0) second_c = c;
         end
      end
      sample_valid = 1'b0;
      result_ready = 1'b0;
      n_cmp++; if (first_c !== 10) begin n_bad++; $display("FAIL b2b_first: got %0d want 10", first_c); end
      n_cmp++; if (second_c !== 21) begin n_bad++; $display("FAIL b2b_second: got %0d want 21", second_c); end
      n_cmp++; if (n_valid !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", n_valid); end
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      x_in         = '0;
      d_in         = '0;
      adapt_en     = 1'b0;
      mu_shift     = '0;
      coef_wr_en   = 1'b0;
      coef_wr_addr = '0;
      coef_wr_data = '0;
      soft_clear   = 1'b0;
      result_ready = 1'b0;
`ifdef FIR_COEF_READBACK_EN
      coef_rd_addr = '0;
`endif
      test_reset();
      test_single_tap();
      test_impulse();
      test_saturation();
      test_lms_update();
      test_busy_rules();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
